// File: rtl/pll_lock_monitor.sv
// -----------------------------------------------------------------------------
// pll_lock_monitor
//
// Lock supervisor and reset sequencer for the HDMI clocking path (27 MHz
// board-oscillator domain). Pulses the rPLL RESET input, watches the
// asynchronous PLL LOCK output through a synchronizer, and releases the
// downstream active-low reset only once lock has been continuously stable.
// A lock timeout retries the PLL; lock losses and retries are counted.
//
// Ports:
//   clk          27 MHz reference clock
//   resetn       synchronous active-low reset
//   pll_lock     raw PLL LOCK, asynchronous to clk
//   pll_reset    PLL RESET, active high (state == RESET_PLL)
//   sys_resetn   active-low reset for the HDMI core (state == RUN)
//   locked       high while in RUN
//   loss_count   saturating count of lock losses seen in RUN
//   retry_count  saturating count of lock timeouts
// -----------------------------------------------------------------------------
module pll_lock_monitor #(
   parameter int SYNC_STAGES         = 2,
   parameter int PLL_RST_CYCLES      = 27,
   parameter int LOCK_STABLE_CYCLES  = 2700,
   parameter int LOCK_TIMEOUT_CYCLES = 270000,
   parameter int CNT_W               = 20
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic       sys_resetn,
   output logic       locked,
   output logic [7:0] loss_count,
   output logic [7:0] retry_count
);

   typedef enum logic [1:0] {
      RESET_PLL = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

   state_t                 state;
   state_t                 state_nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   lock_s;
   logic [CNT_W-1:0]       cnt;
   logic                   retry_inc;
   logic                   loss_inc;

   // Lock synchronizer; only the last stage is allowed to reach the FSM.
   always_ff @(posedge clk) begin
      if (!resetn) sync <= '0;
      else         sync <= {sync[SYNC_STAGES-2:0], pll_lock};
   end

   assign lock_s = sync[SYNC_STAGES-1];

   // Next-state logic. In WAIT_LOCK the lock test comes before the timeout,
   // and in STABLE the drop test comes before the stable-window end, so the
   // lock level always wins a tie with the counter.
   always_comb begin
      state_nxt = state;
      retry_inc = 1'b0;
      loss_inc  = 1'b0;
      case (state)
         RESET_PLL: begin
            if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_nxt = STABLE;
            end else if (cnt == TIMEOUT_LAST) begin
               state_nxt = RESET_PLL;
               retry_inc = 1'b1;
            end
         end
         STABLE: begin
            if (!lock_s)                 state_nxt = WAIT_LOCK;
            else if (cnt == STABLE_LAST) state_nxt = RUN;
         end
         RUN: begin
            // Loss does not reset the PLL; only a later timeout does.
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
               loss_inc  = 1'b1;
            end
         end
         default: state_nxt = RESET_PLL;
      endcase
   end

   // State, shared cycle counter (restarts on every transition), debug counts.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= RESET_PLL;
         cnt         <= '0;
         loss_count  <= '0;
         retry_count <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) cnt <= '0;
         else                    cnt <= cnt + CNT_W'(1);
         if (retry_inc && (retry_count != 8'hFF)) retry_count <= retry_count + 8'd1;
         if (loss_inc  && (loss_count  != 8'hFF)) loss_count  <= loss_count + 8'd1;
      end
   end

   // Outputs depend on the state register only.
   assign pll_reset  = (state == RESET_PLL);
   assign sys_resetn = (state == RUN);
   assign locked     = (state == RUN);

endmodule
